shift_and_subtract: RTL

SHIFT_AND_SUBTRACT -- requirements
Module: shift_and_subtract

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 35 +++
 rtl/shift_and_subtract.sv | 107 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the shift_and_subtract restoring divider:
// default width, FSM state type and the divide-by-zero quotient pattern.
package div_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Wide enough for any supported WIDTH; users take the low WIDTH bits.
    localparam logic [63:0] QUOT_ALL_ONES = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore, and shift the quotient bit in.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic             trial_unused_msb;

    // The extra top bit of the subtraction is the borrow, i.e. the trial sign.
    always_comb begin
        shifted          = {acc, q[WIDTH-1]};
        trial            = {1'b0, shifted} - {2'b00, divisor};
        borrow           = trial[WIDTH+1];
        trial_unused_msb = trial[WIDTH];
        if (!borrow) begin
            acc_next = trial[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = shifted[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/shift_and_subtract.sv
// Multi-cycle restoring divider, one quotient bit per RUN cycle.
// Macro DIV_ZERO_CHECK_EN enables the divide-by-zero fast path and flag.
module shift_and_subtract
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    count;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc),
        .q       (q),
        .divisor (dvsr),
        .acc_next(acc_next),
        .q_next  (q_next)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Published results change only on the edge into DONE; working registers
    // acc/q are private so a new start never disturbs the held outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            q         <= '0;
            dvsr      <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        q     <= dividend;
                        dvsr  <= divisor;
                        count <= '0;
`ifdef DIV_ZERO_CHECK_EN
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= QUOT_ALL_ONES[WIDTH-1:0];
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state     <= DONE;
                        quotient  <= q_next;
                        remainder <= acc_next;
`ifdef DIV_ZERO_CHECK_EN
                        div_by_zero <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef DIV_ZERO_CHECK_EN
    assign div_by_zero = 1'b0;
`endif

endmodule
